accel_smoother: RTL and testbench
=================================

Name: accel_smoother

Overview:
Conditioning stage between AccelerometerCtl and accel_threshold_ticker.
- Samples raw 9-bit X/Y acceleration at a fixed rate.
- Box-averages each axis over a power-of-two window and subtracts a user-triggered calibration (tilt-zero) offset.
- Emits saturated 9-bit two's-complement values plus a one-cycle valid pulse; drop-in replacement for the raw accel_x_in/accel_y_in feeding the ticker.

Parameters:
SAMPLE_DIV, 100000, clk cycles per sample tick (1 kHz at 100 MHz); legal >= 4.
AVG_LOG2, 3, log2 of moving-average window depth (8 samples); legal 1..5.
CAL_LOG2, 4, log2 of calibration sample count (16 samples); legal 1..6.

Ports:
clk  input  1  100 MHz system clock
reset  input  1  synchronous, active-low reset
accel_x_in  input  9  raw X, two's complement
accel_y_in  input  9  raw Y, two's complement
cal_req  input  1  one-cycle pulse (debounced button edge) requesting recalibration
accel_x_out  output  9  filtered, offset-corrected X, two's complement
accel_y_out  output  9  filtered, offset-corrected Y
out_valid  output  1  one-cycle pulse when outputs update
cal_busy  output  1  high while calibration accumulates
filled  output  1  high once averaging window holds WINDOW real samples

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (reset == 0 sampled on rising clk).
- Reset values:
  - all outputs 0
  - tick counter, sums, buffer pointer, fill count, offsets, cal accumulators 0
  - buffer contents need not be cleared (fill gating covers them)
  - state = FILL
- Tick: counter runs 0..SAMPLE_DIV-1; tick asserted in the cycle counter == SAMPLE_DIV-1, then wraps to 0. First tick occurs SAMPLE_DIV cycles after reset release.
- Pipeline per tick; cycle T = tick cycle:
  - T: raw_x/raw_y <= inputs.
  - T+1: sum <= sum + raw - buf[ptr]. In FILL, the subtracted term is 0. buf[ptr] <= raw; ptr <= ptr+1 (mod WINDOW).
  - T+2: out <= sat9((sum >>> AVG_LOG2) - offset); out_valid = 1 for this cycle only. Suppressed (outputs held, no pulse) while state = FILL.
- Widths:
  - sum is 9+AVG_LOG2 bits signed.
  - Averaging shift is arithmetic (floor toward -inf).
  - Difference is computed at 10 bits.
  - sat9 clamps to [-256, +255].
- States:
  - FILL: count ticks; after WINDOW-th sample written -> RUN, filled = 1 (stays 1 until reset). cal_req ignored.
  - RUN: normal output. cal_req = 1 -> CAL; cal accumulators and cal count cleared in the same cycle.
  - CAL: cal_busy = 1.
    - Each tick's filtered average (pre-offset) is added to cal_acc (9+CAL_LOG2 bits signed).
    - Outputs keep updating using the old offset.
    - After 2^CAL_LOG2 accumulations: offset <= cal_acc >>> CAL_LOG2; cal_busy falls; -> RUN. New offset applies from the next out_valid.
    - cal_req while CAL is ignored (no restart).
- Simultaneous events:
  - cal_req in the same cycle as a tick: the transition to CAL occurs; that tick's average is the first one accumulated.
  - Final cal accumulation coincides with output stage: output uses the old offset.
- Reset mid-CAL or mid-FILL: everything returns to reset values; offset becomes 0 (previous calibration lost).
- Independent axes share the tick, state, pointer and cal counter.

Decomposition:
- Shared package accel_pkg:
  - ACCEL_W = 9
  - SAT_MAX = 255, SAT_MIN = -256
  - state encoding FILL/RUN/CAL
- One natural sub-module, accel_box_filter: per-axis window buffer + running sum. Instantiated twice (X, Y), sharing ptr and tick from the parent. FSM, tick counter, calibration and saturation stay in the parent.

Test Plan:
1. Reset: hold reset = 0 for 5 cycles with inputs 37 -> all outputs 0, out_valid 0, filled 0; release with SAMPLE_DIV = 4 -> first out_valid exactly at tick 8 + 2 cycles, X = 37.
2. Step: after filled, X steps 0 -> 80 -> outputs 10, 20, ..., 80 on successive out_valid (AVG_LOG2 = 3); Y = -3 constant stays -3; Y = -1 on one sample of eight over 0s -> -1 (floor).
3. Calibration: constant X = 30, Y = -12, pulse cal_req -> cal_busy high for 16 ticks, outputs 30/-12 during CAL, then 0/0 from next out_valid.
4. Saturation: calibrate at X = 200, then X = -200 -> out -256; calibrate at X = -200, then X = 200 -> out +255.
5. Edge cases: cal_req during FILL and during CAL -> ignored (cal_busy unchanged, no restart); cal_req coincident with tick -> 16 accumulations counted from that tick.
6. Reset mid-CAL (tick 7 of 16) -> offset 0, state FILL, outputs 0; after refill, raw value appears uncorrected.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared widths, saturation limits and FSM encoding for the accelerometer smoother.
package accel_pkg;

    localparam int unsigned ACCEL_W = 9;
    localparam int SAT_MAX = 255;
    localparam int SAT_MIN = -256;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAL  = 2'd2
    } state_t;

    // Clamp a 10-bit signed difference into the 9-bit output range.
    function automatic logic signed [ACCEL_W-1:0] sat9(input logic signed [ACCEL_W:0] d);
        if (int'(d) > SAT_MAX) begin
            return ACCEL_W'(SAT_MAX);
        end else if (int'(d) < SAT_MIN) begin
            return ACCEL_W'(SAT_MIN);
        end
        return ACCEL_W'(d);
    endfunction

endpackage

// File: rtl/accel_box_filter.sv
// Per-axis window buffer and running sum for the box average.
module accel_box_filter
    import accel_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_en,
    input  logic                                 i_fill,
    input  logic [AVG_LOG2-1:0]                  i_ptr,
    input  logic signed [ACCEL_W-1:0]            i_raw,
    output logic signed [ACCEL_W+AVG_LOG2-1:0]   o_sum
);

    localparam int unsigned WINDOW = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = ACCEL_W + AVG_LOG2;

    logic signed [ACCEL_W-1:0] r_buf [WINDOW];
    logic signed [SUM_W-1:0]   r_sum;
    logic signed [SUM_W-1:0]   w_drop;

    // Slots not yet written during fill hold garbage, so nothing is retired then.
    always_comb begin
        w_drop = '0;
        if (!i_fill) begin
            w_drop = SUM_W'(r_buf[i_ptr]);
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_buf[i_ptr] <= i_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + SUM_W'(i_raw) - w_drop;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/accel_smoother.sv
// Sample-rate decimation, box averaging, tilt-zero calibration and saturation
// for the X/Y accelerometer channels.
module accel_smoother
    import accel_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100000,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned CAL_LOG2   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [ACCEL_W-1:0] accel_x_in,
    input  logic signed [ACCEL_W-1:0] accel_y_in,
    input  logic                      cal_req,
    output logic signed [ACCEL_W-1:0] accel_x_out,
    output logic signed [ACCEL_W-1:0] accel_y_out,
    output logic                      out_valid,
    output logic                      cal_busy,
    output logic                      filled
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned WINDOW = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = ACCEL_W + AVG_LOG2;
    localparam int unsigned CACC_W = ACCEL_W + CAL_LOG2;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_s1;
    logic                      r_s2;
    logic [AVG_LOG2-1:0]       r_ptr;
    logic signed [ACCEL_W-1:0] r_raw_x, r_raw_y;
    logic signed [ACCEL_W-1:0] r_off_x, r_off_y;
    logic signed [CACC_W-1:0]  r_acc_x, r_acc_y;
    logic [CAL_LOG2-1:0]       r_cal_cnt;
    logic signed [ACCEL_W-1:0] r_out_x, r_out_y;
    logic                      r_out_valid;
    logic                      r_cal_busy;
    logic                      r_filled;

    logic                      w_tick;
    logic                      w_fill;
    logic signed [SUM_W-1:0]   w_sum_x, w_sum_y;
    logic signed [ACCEL_W-1:0] w_avg_x, w_avg_y;
    logic signed [ACCEL_W:0]   w_diff_x, w_diff_y;
    logic signed [CACC_W-1:0]  w_acc_nx_x, w_acc_nx_y;

    assign w_tick = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign w_fill = (r_state == ST_FILL);

    accel_box_filter #(.AVG_LOG2(AVG_LOG2)) u_filt_x (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_s1),
        .i_fill (w_fill),
        .i_ptr  (r_ptr),
        .i_raw  (r_raw_x),
        .o_sum  (w_sum_x)
    );

    accel_box_filter #(.AVG_LOG2(AVG_LOG2)) u_filt_y (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_s1),
        .i_fill (w_fill),
        .i_ptr  (r_ptr),
        .i_raw  (r_raw_y),
        .o_sum  (w_sum_y)
    );

    // Floor-average, offset correction at 10 bits, and next calibration accumulator.
    always_comb begin
        w_avg_x    = ACCEL_W'(w_sum_x >>> AVG_LOG2);
        w_avg_y    = ACCEL_W'(w_sum_y >>> AVG_LOG2);
        w_diff_x   = {w_avg_x[ACCEL_W-1], w_avg_x} - {r_off_x[ACCEL_W-1], r_off_x};
        w_diff_y   = {w_avg_y[ACCEL_W-1], w_avg_y} - {r_off_y[ACCEL_W-1], r_off_y};
        w_acc_nx_x = r_acc_x + CACC_W'(w_avg_x);
        w_acc_nx_y = r_acc_y + CACC_W'(w_avg_y);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_cnt       <= '0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_ptr       <= '0;
            r_raw_x     <= '0;
            r_raw_y     <= '0;
            r_off_x     <= '0;
            r_off_y     <= '0;
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_cal_cnt   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
            r_cal_busy  <= 1'b0;
            r_filled    <= 1'b0;
        end else begin
            r_cnt       <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_s1        <= w_tick;
            r_s2        <= r_s1;
            r_out_valid <= 1'b0;

            if (w_tick) begin
                r_raw_x <= accel_x_in;
                r_raw_y <= accel_y_in;
            end

            if (r_s1) begin
                r_ptr <= r_ptr + AVG_LOG2'(1);
            end

            // Output stage always uses the offset held before this edge.
            if (r_s2 && !w_fill) begin
                r_out_x     <= sat9(w_diff_x);
                r_out_y     <= sat9(w_diff_y);
                r_out_valid <= 1'b1;
            end

            case (r_state)
                ST_FILL: begin
                    if (r_s1 && r_ptr == AVG_LOG2'(WINDOW - 1)) begin
                        r_state  <= ST_RUN;
                        r_filled <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cal_req) begin
                        r_state    <= ST_CAL;
                        r_cal_busy <= 1'b1;
                        r_acc_x    <= '0;
                        r_acc_y    <= '0;
                        r_cal_cnt  <= '0;
                    end
                end
                ST_CAL: begin
                    if (r_s2) begin
                        r_acc_x   <= w_acc_nx_x;
                        r_acc_y   <= w_acc_nx_y;
                        r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
                        if (r_cal_cnt == '1) begin
                            r_off_x    <= ACCEL_W'(w_acc_nx_x >>> CAL_LOG2);
                            r_off_y    <= ACCEL_W'(w_acc_nx_y >>> CAL_LOG2);
                            r_state    <= ST_RUN;
                            r_cal_busy <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign accel_x_out = r_out_x;
    assign accel_y_out = r_out_y;
    assign out_valid   = r_out_valid;
    assign cal_busy    = r_cal_busy;
    assign filled      = r_filled;

endmodule

// File: tb/tb_accel_smoother.sv
// Directed bench for accel_smoother with a short sample period (SAMPLE_DIV = 4).
module tb_accel_smoother;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [8:0] accel_x_in;
    logic signed [8:0] accel_y_in;
    logic              cal_req;
    logic signed [8:0] accel_x_out;
    logic signed [8:0] accel_y_out;
    logic              out_valid;
    logic              cal_busy;
    logic              filled;

    int n_checks = 0;
    int n_fail   = 0;

    accel_smoother #(.SAMPLE_DIV(4), .AVG_LOG2(3), .CAL_LOG2(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .accel_x_in  (accel_x_in),
        .accel_y_in  (accel_y_in),
        .cal_req     (cal_req),
        .accel_x_out (accel_x_out),
        .accel_y_out (accel_y_out),
        .out_valid   (out_valid),
        .cal_busy    (cal_busy),
        .filled      (filled)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next out_valid pulse (sampled on the falling edge).
    task automatic next_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check("valid_timeout", 0, 1);
    endtask

    task automatic settle(input int n, input string tag, input int ex, input int ey);
        for (int i = 0; i < n; i++) next_valid(12);
        check({tag, "_x"}, accel_x_out, ex);
        check({tag, "_y"}, accel_y_out, ey);
    endtask

    task automatic pulse_cal();
        cal_req = 1'b1;
        @(negedge clk);
        cal_req = 1'b0;
    endtask

    // Called right after a valid: the following cycle is the tick cycle.
    task automatic pulse_cal_on_tick();
        @(negedge clk);
        pulse_cal();
    endtask

    // Run a full 16-tick calibration, checking the busy window and held outputs.
    task automatic run_cal(input string tag, input int ex, input int ey, input bit poke_mid);
        check({tag, "_busy_start"}, cal_busy, 1);
        for (int j = 1; j <= 16; j++) begin
            next_valid(12);
            check({tag, "_hold_x"}, accel_x_out, ex);
            check({tag, "_hold_y"}, accel_y_out, ey);
            if (j == 15) check({tag, "_busy_15"}, cal_busy, 1);
            if (j == 16) check({tag, "_busy_16"}, cal_busy, 0);
            if (poke_mid && j == 5) pulse_cal();
        end
    endtask

    int early_valid;
    int busy_seen;
    int filled_at_32;

    initial begin
        reset = 1'b0;
        accel_x_in = 9'sd37;
        accel_y_in = 9'sd37;
        cal_req = 1'b0;

        repeat (5) @(negedge clk);
        check("rst_x", accel_x_out, 0);
        check("rst_y", accel_y_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_filled", filled, 0);
        check("rst_busy", cal_busy, 0);

        // First valid must appear two edges after the 8th tick edge (edge 34).
        reset = 1'b1;
        early_valid = 0;
        busy_seen = 0;
        filled_at_32 = -1;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 34 && out_valid) early_valid++;
            if (cal_busy) busy_seen++;
            if (i == 32) filled_at_32 = filled;
            if (i == 10) cal_req = 1'b1;
            if (i == 11) cal_req = 1'b0;
        end
        check("first_valid_early", early_valid, 0);
        check("first_valid", out_valid, 1);
        check("first_x", accel_x_out, 37);
        check("first_y", accel_y_out, 37);
        check("filled_before", filled_at_32, 0);
        check("filled_after", filled, 1);
        check("fill_cal_ignored", busy_seen, 0);

        // Step response and floor behaviour.
        accel_x_in = 9'sd0;
        accel_y_in = -9'sd3;
        settle(8, "zero", 0, -3);
        accel_x_in = 9'sd80;
        for (int k = 1; k <= 8; k++) begin
            next_valid(12);
            check("step_x", accel_x_out, 10 * k);
            check("step_y", accel_y_out, -3);
        end
        accel_y_in = 9'sd0;
        settle(8, "yzero", 80, 0);
        accel_y_in = -9'sd1;
        next_valid(12);
        accel_y_in = 9'sd0;
        check("floor_y", accel_y_out, -1);
        check("floor_x", accel_x_out, 80);

        // Calibration with a redundant request mid-way that must not restart it.
        accel_x_in = 9'sd30;
        accel_y_in = -9'sd12;
        settle(8, "precal", 30, -12);
        pulse_cal();
        run_cal("cal1", 30, -12, 1'b1);
        next_valid(12);
        check("cal1_zero_x", accel_x_out, 0);
        check("cal1_zero_y", accel_y_out, 0);

        // Saturation low, with the request landing on a tick cycle.
        accel_x_in = 9'sd200;
        settle(8, "pre_sat_lo", 170, 0);
        pulse_cal_on_tick();
        run_cal("cal2", 170, 0, 1'b0);
        accel_x_in = -9'sd200;
        settle(8, "sat_lo", -256, 0);

        // Saturation high.
        pulse_cal();
        run_cal("cal3", -256, 0, 1'b0);
        accel_x_in = 9'sd200;
        settle(8, "sat_hi", 255, 0);

        // Reset partway through calibration drops the offset.
        accel_x_in = 9'sd50;
        accel_y_in = 9'sd7;
        settle(8, "pre_mid", 250, 19);
        pulse_cal();
        for (int j = 0; j < 7; j++) next_valid(12);
        check("mid_busy", cal_busy, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_x", accel_x_out, 0);
        check("mid_rst_y", accel_y_out, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_filled", filled, 0);
        check("mid_rst_busy", cal_busy, 0);
        reset = 1'b1;
        next_valid(80);
        check("refill_x", accel_x_out, 50);
        check("refill_y", accel_y_out, 7);
        check("refill_filled", filled, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
